// File: rtl/seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// seg_display_ctrl
// Round-robin arbiter, capture, shared hex decoder and atomic commit of four
// 7-segment bytes {dp,g,f,e,d,c,b,a} with per-digit blink gating.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module seg_display_ctrl #(
  parameter logic [23:0] BLINK_DIV = 24'd6000000
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        REQ0,
  input  logic [15:0] VAL0,
  input  logic [3:0]  DP0,
  input  logic [3:0]  BLK0,
  output logic        ACK0,
  input  logic        REQ1,
  input  logic [15:0] VAL1,
  input  logic [3:0]  DP1,
  input  logic [3:0]  BLK1,
  output logic        ACK1,
  output logic [7:0]  DIG0,
  output logic [7:0]  DIG1,
  output logic [7:0]  DIG2,
  output logic [7:0]  DIG3,
  output logic        BUSY,
  output logic        OWNER
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_DECODE  = 2'd2,
    S_COMMIT  = 2'd3
  } state_t;

  state_t          state;
  logic            last_grant;
  logic            win;
  logic            grant;
  logic [15:0]     cap_val;
  logic [3:0]      cap_dp;
  logic [3:0]      cap_blk;
  logic [1:0]      idx;
  logic [3:0]      nibble;
  logic [6:0]      seg7;
  logic [3:0][7:0] shadow;
  logic [3:0][7:0] com_bytes;
  logic [3:0]      com_blk;
  logic [3:0][7:0] next_bytes;
  logic [3:0]      next_blk;
  logic [23:0]     blink_cnt;
  logic            phase;
  logic            wrap;
  logic            next_phase;

  // Arbitration: a lone requester wins; on a tie the one not granted last wins
  always_comb begin
    grant = 1'b0;
    if (REQ0 && REQ1) begin
      grant = ~last_grant;
    end else if (REQ1) begin
      grant = 1'b1;
    end
  end

  // Shared hex-to-segment decoder fed by the nibble selected by the digit index
  always_comb begin
    nibble = cap_val[{idx, 2'b00} +: 4];
    case (nibble)
      4'h0: seg7 = 7'h3F;
      4'h1: seg7 = 7'h06;
      4'h2: seg7 = 7'h5B;
      4'h3: seg7 = 7'h4F;
      4'h4: seg7 = 7'h66;
      4'h5: seg7 = 7'h6D;
      4'h6: seg7 = 7'h7D;
      4'h7: seg7 = 7'h07;
      4'h8: seg7 = 7'h7F;
      4'h9: seg7 = 7'h6F;
      4'hA: seg7 = 7'h77;
      4'hB: seg7 = 7'h7C;
      4'hC: seg7 = 7'h39;
      4'hD: seg7 = 7'h5E;
      4'hE: seg7 = 7'h79;
      default: seg7 = 7'h71;
    endcase
  end

  // Update sequencer: sample/capture, acknowledge, decode four digits, commit
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
      win        <= 1'b0;
      cap_val    <= 16'h0000;
      cap_dp     <= 4'h0;
      cap_blk    <= 4'h0;
      idx        <= 2'd0;
      shadow     <= '0;
      ACK0       <= 1'b0;
      ACK1       <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      ACK0 <= 1'b0;
      ACK1 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (REQ0 || REQ1) begin
            win        <= grant;
            last_grant <= grant;
            cap_val    <= grant ? VAL1 : VAL0;
            cap_dp     <= grant ? DP1  : DP0;
            cap_blk    <= grant ? BLK1 : BLK0;
            BUSY       <= 1'b1;
            state      <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          ACK0  <= ~win;
          ACK1  <= win;
          idx   <= 2'd0;
          state <= S_DECODE;
        end
        S_DECODE: begin
          shadow[idx] <= {cap_dp[idx], seg7};
          idx         <= idx + 2'd1;
          if (idx == 2'd3) begin
            state <= S_COMMIT;
          end
        end
        S_COMMIT: begin
          BUSY  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign wrap = (blink_cnt == BLINK_DIV - 24'd1);

  // Free-running blink timebase, independent of the update sequencer
  always_ff @(posedge CLK) begin
    if (RST) begin
      blink_cnt <= 24'd0;
      phase     <= 1'b0;
    end else if (wrap) begin
      blink_cnt <= 24'd0;
      phase     <= ~phase;
    end else begin
      blink_cnt <= blink_cnt + 24'd1;
    end
  end

  // Values the display will hold after this edge, so a commit and a blink
  // toggle landing on the same edge are both reflected immediately
  always_comb begin
    next_phase = phase ^ wrap;
    next_bytes = com_bytes;
    next_blk   = com_blk;
    if (state == S_COMMIT) begin
      next_bytes = shadow;
      next_blk   = cap_blk;
    end
  end

  // Committed digits, blink mask and owner, plus the gated output bytes
  always_ff @(posedge CLK) begin
    if (RST) begin
      com_bytes <= '0;
      com_blk   <= 4'h0;
      OWNER     <= 1'b0;
      DIG0      <= 8'h00;
      DIG1      <= 8'h00;
      DIG2      <= 8'h00;
      DIG3      <= 8'h00;
    end else begin
      com_bytes <= next_bytes;
      com_blk   <= next_blk;
      if (state == S_COMMIT) begin
        OWNER <= win;
      end
      DIG0 <= (next_phase && next_blk[0]) ? 8'h00 : next_bytes[0];
      DIG1 <= (next_phase && next_blk[1]) ? 8'h00 : next_bytes[1];
      DIG2 <= (next_phase && next_blk[2]) ? 8'h00 : next_bytes[2];
      DIG3 <= (next_phase && next_blk[3]) ? 8'h00 : next_bytes[3];
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_display_ctrl
// Self-checking bench: transaction-level reference model compared every
// cycle, directed scenarios with literal expectations, randomized traffic.
// Rev 1.0 - initial release
// ---------------------------------------------------------------------------
`default_nettype none

module tb_seg_display_ctrl;

  localparam int BDIV = 4;

  logic        CLK;
  logic        RST;
  logic        REQ0, REQ1;
  logic [15:0] VAL0, VAL1;
  logic [3:0]  DP0, DP1, BLK0, BLK1;
  logic        ACK0, ACK1, BUSY, OWNER;
  logic [7:0]  DIG0, DIG1, DIG2, DIG3;

  int n_checks = 0;
  int n_errs   = 0;

  seg_display_ctrl #(.BLINK_DIV(24'd4)) dut (
    .CLK(CLK), .RST(RST),
    .REQ0(REQ0), .VAL0(VAL0), .DP0(DP0), .BLK0(BLK0), .ACK0(ACK0),
    .REQ1(REQ1), .VAL1(VAL1), .DP1(DP1), .BLK1(BLK1), .ACK1(ACK1),
    .DIG0(DIG0), .DIG1(DIG1), .DIG2(DIG2), .DIG3(DIG3),
    .BUSY(BUSY), .OWNER(OWNER)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] tbl [16] = '{8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
                           8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71};

  int          m_e = 0;        // edges since reset
  int          m_t = 0;        // edges since the sampling edge of the update
  bit          m_busy = 0;
  bit          m_last = 1;
  bit          m_win = 0;
  bit          m_owner = 0;
  bit          e_ack0 = 0, e_ack1 = 0;
  logic [15:0] m_val = '0;
  logic [3:0]  m_dp = '0, m_blk = '0, m_blk_c = '0;
  logic [7:0]  m_bytes [4] = '{8'h00, 8'h00, 8'h00, 8'h00};
  bit          atomic_mode = 0;
  logic [31:0] atomic_old = '0;

  always @(posedge CLK) begin
    logic [31:0] exp_vec;
    bit          phase;
    if (RST) begin
      m_e = 0; m_t = 0; m_busy = 0; m_last = 1; m_win = 0; m_owner = 0;
      e_ack0 = 0; e_ack1 = 0; m_blk_c = '0;
      for (int n = 0; n < 4; n++) m_bytes[n] = 8'h00;
    end else begin
      m_e++;
      e_ack0 = 0; e_ack1 = 0;
      if (m_busy) begin
        m_t++;
        if (m_t == 1) begin
          if (m_win) e_ack1 = 1; else e_ack0 = 1;
        end
        if (m_t == 6) begin
          for (int n = 0; n < 4; n++) m_bytes[n] = {m_dp[n], tbl[m_val[4*n +: 4]][6:0]};
          m_blk_c = m_blk;
          m_owner = m_win;
          m_busy  = 0;
        end
      end else if (REQ0 || REQ1) begin
        m_win  = (REQ0 && REQ1) ? !m_last : REQ1;
        m_last = m_win;
        m_val  = m_win ? VAL1 : VAL0;
        m_dp   = m_win ? DP1  : DP0;
        m_blk  = m_win ? BLK1 : BLK0;
        m_busy = 1;
        m_t    = 0;
      end
    end
    phase = ((m_e / BDIV) % 2) == 1;
    for (int n = 0; n < 4; n++)
      exp_vec[8*n +: 8] = (phase && m_blk_c[n]) ? 8'h00 : m_bytes[n];
    #1;
    chk("digits", {DIG3, DIG2, DIG1, DIG0}, exp_vec);
    chk("ack_busy_owner", {28'd0, ACK1, ACK0, BUSY, OWNER},
        {28'd0, e_ack1, e_ack0, m_busy, m_owner});
    if (atomic_mode)
      chk("atomic", {31'd0, ({DIG3, DIG2, DIG1, DIG0} == atomic_old) ||
                            ({DIG3, DIG2, DIG1, DIG0} == 32'h71717171)}, 32'd1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    while (BUSY && n < 40) begin
      @(negedge CLK);
      n++;
    end
    chk(name, {31'd0, BUSY}, 32'd0);
  endtask

  task automatic send(input bit which, input logic [15:0] v, input logic [3:0] d,
                      input logic [3:0] b);
    int n = 0;
    @(negedge CLK);
    if (!which) begin REQ0 = 1; VAL0 = v; DP0 = d; BLK0 = b; end
    else        begin REQ1 = 1; VAL1 = v; DP1 = d; BLK1 = b; end
    do begin
      @(negedge CLK);
      n++;
    end while (!(which ? ACK1 : ACK0) && n < 30);
    chk("ack_seen", {31'd0, (which ? ACK1 : ACK0)}, 32'd1);
    if (!which) REQ0 = 0; else REQ1 = 0;
    wait_idle("idle_after_send");
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int          n;
    int          nacks;
    logic [3:0]  seq;
    logic [31:0] pos;
    logic [7:0]  s [17];
    int          last_chg;
    int          nchg;

    RST = 1; REQ0 = 0; REQ1 = 0;
    VAL0 = '0; VAL1 = '0; DP0 = '0; DP1 = '0; BLK0 = '0; BLK1 = '0;
    repeat (3) @(negedge CLK);
    RST = 0;

    // reset then idle
    repeat (20) @(negedge CLK);
    chk("idle_digits", {DIG3, DIG2, DIG1, DIG0}, 32'h0);
    chk("idle_busy", {31'd0, BUSY}, 32'd0);

    // single request from requester 0
    send(0, 16'h1234, 4'b0001, 4'b0000);
    chk("val_1234", {DIG3, DIG2, DIG1, DIG0}, 32'h065B4FE6);
    chk("owner0", {31'd0, OWNER}, 32'd0);

    // atomic replacement of 1234 by FFFF
    atomic_old  = 32'h065B4FE6;
    atomic_mode = 1;
    send(0, 16'hFFFF, 4'b0000, 4'b0000);
    @(negedge CLK);
    atomic_mode = 0;
    chk("val_ffff", {DIG3, DIG2, DIG1, DIG0}, 32'h71717171);

    // request 1 with a one-cycle REQ0 pulse while busy
    @(negedge CLK);
    REQ1 = 1; VAL1 = 16'h5678; DP1 = 4'b0000; BLK1 = 4'b0000;
    n = 0;
    do begin @(negedge CLK); n++; end while (!ACK1 && n < 30);
    chk("ack1_seen", {31'd0, ACK1}, 32'd1);
    REQ1 = 0;
    REQ0 = 1; VAL0 = 16'h0000; DP0 = 4'hF;
    @(negedge CLK);
    REQ0 = 0;
    wait_idle("idle_after_pulse");
    repeat (3) @(negedge CLK);
    chk("val_5678", {DIG3, DIG2, DIG1, DIG0}, 32'h6D7D077F);
    chk("owner1", {31'd0, OWNER}, 32'd1);

    // both requesters held: grants must alternate starting with 0
    REQ0 = 1; VAL0 = 16'h0F0F; DP0 = 4'b0000; BLK0 = 4'b0000;
    REQ1 = 1; VAL1 = 16'hF0F0; DP1 = 4'b0000; BLK1 = 4'b0000;
    nacks = 0; seq = '0; pos = '0;
    for (int i = 0; i < 28; i++) begin
      @(negedge CLK);
      chk("ack_exclusive", {31'd0, ACK0 && ACK1}, 32'd0);
      if ((ACK0 || ACK1) && nacks < 4) begin
        seq = {seq[2:0], ACK1};
        pos = {pos[23:0], 8'(i)};
        nacks++;
      end
    end
    REQ0 = 0; REQ1 = 0;
    wait_idle("idle_after_tie");
    chk("tie_count", nacks, 32'd4);
    chk("tie_order", {28'd0, seq}, 32'b0101);
    chk("tie_spacing", pos, {8'd1, 8'd8, 8'd15, 8'd22});

    // blink digit 3 of ABCD
    send(1, 16'hABCD, 4'b0000, 4'b1000);
    last_chg = -1; nchg = 0;
    for (int i = 0; i < 17; i++) begin
      @(negedge CLK);
      s[i] = DIG3;
      chk("blink_steady", {8'd0, DIG2, DIG1, DIG0}, 32'h007C395E);
      chk("blink_value", {31'd0, (DIG3 == 8'h77) || (DIG3 == 8'h00)}, 32'd1);
      if (i > 0 && s[i] != s[i-1]) begin
        if (last_chg >= 0) chk("blink_period", i - last_chg, 32'd4);
        last_chg = i;
        nchg++;
      end
    end
    chk("blink_toggled", {31'd0, nchg >= 3}, 32'd1);

    // reset during DECODE aborts the update
    @(negedge CLK);
    REQ0 = 1; VAL0 = 16'h8888; DP0 = 4'hF; BLK0 = 4'h0;
    n = 0;
    do begin @(negedge CLK); n++; end while (!ACK0 && n < 30);
    chk("ack0_pre_reset", {31'd0, ACK0}, 32'd1);
    REQ0 = 0;
    @(negedge CLK);
    RST = 1;
    @(posedge CLK);
    #2;
    chk("rst_digits", {DIG3, DIG2, DIG1, DIG0}, 32'h0);
    chk("rst_ctl", {29'd0, ACK1, ACK0, BUSY}, 32'd0);
    @(negedge CLK);
    RST = 0;
    nacks = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (ACK0 || ACK1 || BUSY) nacks++;
    end
    chk("post_reset_quiet", nacks, 32'd0);

    // randomized traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      @(negedge CLK);
      RST  = ($urandom_range(0, 63) == 0);
      REQ0 = ($urandom_range(0, 2) == 0);
      REQ1 = ($urandom_range(0, 2) == 0);
      VAL0 = 16'($urandom); VAL1 = 16'($urandom);
      DP0  = 4'($urandom);  DP1  = 4'($urandom);
      BLK0 = 4'($urandom);  BLK1 = 4'($urandom);
    end
    @(negedge CLK);
    RST = 0; REQ0 = 0; REQ1 = 0;
    wait_idle("idle_after_random");
    repeat (4) @(negedge CLK);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/seg_display_ctrl.md
# seg_display_ctrl

Scheduler and formatter in front of the 4-digit 7-segment multiplexer. Two requesters (for example the processor debug port and a status source) share the display through a round-robin request/acknowledge arbiter. The winner's 16-bit hex value, decimal-point mask and blink mask are captured, then decoded nibble-by-nibble through one shared hex-to-segment decoder. The result drives four registered segment bytes that feed the digit-multiplexing display block.

## Interface

- BLINK_DIV, default 24'd6000000: blink half-period in CLK cycles; minimum 2.
- CLK  in  1  system clock; all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ0  in  1  requester 0 update request; held until ACK0.
- VAL0  in  16  requester 0 hex value; [3:0] is digit 0 (rightmost).
- DP0  in  4  requester 0 decimal-point mask; bit n is digit n.
- BLK0  in  4  requester 0 blink mask; bit n is digit n.
- ACK0  out  1  one-cycle pulse: requester 0 payload captured.
- REQ1, VAL1, DP1, BLK1, ACK1: same as above, for requester 1.
- DIG0..DIG3  out  8 each  segment bytes {dp,g,f,e,d,c,b,a}, active-high, to the display multiplexer.
- BUSY  out  1  high in every state except IDLE.
- OWNER  out  1  index of the requester whose data is currently displayed.

## Operation

- FSM states: IDLE, CAPTURE, DECODE, COMMIT.
- IDLE:
  - At each edge where REQ0 or REQ1 is high: pick the winner, latch its VAL/DP/BLK into the capture register, go to CAPTURE.
- Arbitration:
  - Only one requester high: it wins.
  - Both high: the requester not granted last wins.
  - The last-grant pointer resets so that requester 0 wins the first tie.
- CAPTURE:
  - ACK of the winner is high for exactly this cycle.
  - Digit index cleared to 0; go to DECODE.
- DECODE:
  - Each cycle, decode capture nibble [4i+3:4i] into shadow byte i; bit 7 = DPx[i].
  - Index increments; after i=3, go to COMMIT.
- COMMIT:
  - All four shadow bytes, the blink mask and OWNER are transferred together in one edge. DIG outputs never show a mix of old and new digits.
  - Return to IDLE.
- Requests are not sampled outside IDLE. A REQ still high after its ACK is a new request.
- Hex decode table: 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F, A=77, b=7C, C=39, d=5E, E=79, F=71.
- Blink:
  - Free-running counter 0..BLINK_DIV-1. At wrap it returns to 0 and toggles the blink phase.
  - Phase 1: any digit whose committed blink bit is set outputs 8'h00, including dp.
  - Phase 0: committed bytes are shown.
  - The blink counter is independent of the FSM; COMMIT does not restart it.
- DIGn is registered and equals committed byte n gated by (blink phase AND committed blink bit n).

## Timing

- Reset values:
  - DIG0..DIG3 = 8'h00; ACK0 = ACK1 = 0; BUSY = 0; OWNER = 0.
  - FSM in IDLE; blink counter 0, phase 0; committed blink mask 0; last-grant pointer = 1.
- RST in any state aborts the update:
  - Capture and shadow registers discarded; no ACK is issued after reset.
  - Outputs take their reset values on that edge.
- Latency, counting REQ sampled high in IDLE at edge k:
  - ACK high between edges k+1 and k+2.
  - DECODE occupies edges k+2..k+5.
  - COMMIT edge k+6: new DIG values visible after k+6.
  - BUSY high after k..k+6; IDLE again after k+6. The earliest next sampling edge is k+7.
- Throughput: one update per 7 cycles with continuous requests; alternates 0,1,0,1 when both hold REQ.
- A requester dropping REQ after capture does not cancel the update.
- Blink toggle coinciding with COMMIT: on that edge DIG reflects the new bytes, the new mask and the new phase.

## Test plan

- Reset then idle: DIG0..3 = 00 and BUSY = 0 for 20 cycles. Assert RST mid-DECODE: next edge gives DIG = 00, BUSY = 0, no ACK.
- REQ0 with VAL0=16'h1234, DP0=4'b0001, BLK0=0 -> ACK0 one cycle after sampling. Six cycles after sampling: DIG3=06, DIG2=5B, DIG1=4F, DIG0=E6, OWNER=0.
- REQ0 and REQ1 asserted together and held -> grants 0,1,0,1. ACK pulses 7 cycles apart. OWNER alternates and ACK0 and ACK1 are never high together.
- REQ1 with VAL1=16'hABCD, BLK1=4'b1000, BLINK_DIV=4 -> DIG3 toggles between 77 and 00 every 4 cycles. DIG2=7C, DIG1=39, DIG0=5E stay steady.
- Atomicity: while 16'h1234 is displayed, request 16'hFFFF. Check every cycle that DIG is either all-old or all-71, with no mixed value.
- REQ0 pulsed high one cycle during BUSY -> ignored: no ACK0 and display unchanged.
